// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequence engine.
package simon_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_OFF = 3'd3,
        ST_INPUT    = 3'd4,
        ST_RELEASE  = 3'd5,
        ST_WIN      = 3'd6,
        ST_LOSE     = 3'd7
    } state_t;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Width of a colour index: at least one bit even for two colours.
    function automatic int cw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a round counter that must hold 0..m.
    function automatic int rw_of(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/simon_seq_engine_if.sv
// Board-facing pins of the game core: button inputs and colour LED drive.
interface simon_seq_engine_if #(
    parameter int N_COLOURS = 4
) ();
    logic [N_COLOURS-1:0] buttons;
    logic [N_COLOURS-1:0] colour_out;
    logic                 colour_oe;

    modport master (input buttons, output colour_out, output colour_oe);
    modport slave  (output buttons, input colour_out, input colour_oe);
endinterface

// File: rtl/simon_lfsr.sv
// 8-bit right-shifting Galois LFSR; a zero seed is replaced by 8'h01.
module simon_lfsr
    import simon_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       step,
    output logic [7:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 8'h01;
        end else if (load) begin
            q <= (seed == 8'h00) ? 8'h01 : seed;
        end else if (step) begin
            q <= (q >> 1) ^ (q[0] ? LFSR_TAPS : 8'h00);
        end
    end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon Says core: generates a colour sequence, shows it round by round,
// then checks the player's presses with a per-press timeout.
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter  int N_COLOURS      = 4,
    parameter  int MAX_LEN        = 16,
    parameter  int DISPLAY_CYCLES = 1000,
    parameter  int TIMEOUT_CYCLES = 100000,
    localparam int CW             = cw_of(N_COLOURS),
    localparam int RW             = rw_of(MAX_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [7:0]          seed,
    simon_seq_engine_if.master  pins,
    output logic [2:0]          state_dbg,
    output logic [RW-1:0]       round,
    output logic                win,
    output logic                lose
);

    // Sequence index only has to address MAX_LEN entries.
    localparam int IW = cw_of(MAX_LEN);
    localparam int DW = $clog2(DISPLAY_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DISPLAY_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [IW-1:0] G_LAST = IW'(MAX_LEN - 1);
    localparam logic [RW-1:0] LEN    = RW'(MAX_LEN);
    localparam logic [CW:0]   NC     = (CW + 1)'(N_COLOURS);

    state_t               state, state_next;
    logic [IW-1:0]        index, gen_idx;
    logic [DW-1:0]        disp_cnt;
    logic [TW-1:0]        tmo_cnt;
    logic [N_COLOURS-1:0] prev_buttons;
    logic [CW-1:0]        mem [MAX_LEN];
    logic [7:0]           lfsr_q;
    logic [CW:0]          raw;
    logic [CW-1:0]        gen_colour, cur_colour;
    logic [N_COLOURS-1:0] cur_onehot;
    logic                 press, match, disp_done, last_idx;

    simon_lfsr u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (state == ST_IDLE && start),
        .seed (seed),
        .step (state == ST_GEN),
        .q    (lfsr_q)
    );

    // Raw LFSR bits can exceed the colour count by less than N_COLOURS, so one fold suffices.
    assign raw        = {1'b0, lfsr_q[CW-1:0]};
    assign gen_colour = (raw >= NC) ? CW'(raw - NC) : raw[CW-1:0];
    assign cur_colour = mem[index];
    assign cur_onehot = N_COLOURS'(1) << cur_colour;
    assign press      = $onehot(pins.buttons) && (prev_buttons == '0);
    assign match      = (pins.buttons == cur_onehot);
    assign disp_done  = (disp_cnt == D_LAST);
    assign last_idx   = (RW'(index) == round - RW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (start) state_next = ST_GEN;
            ST_GEN:      if (gen_idx == G_LAST) state_next = ST_SHOW_ON;
            ST_SHOW_ON:  if (disp_done) state_next = ST_SHOW_OFF;
            ST_SHOW_OFF: if (disp_done) state_next = last_idx ? ST_INPUT : ST_SHOW_ON;
            ST_INPUT: begin
                if (press)                 state_next = match ? ST_RELEASE : ST_LOSE;
                else if (tmo_cnt == T_LAST) state_next = ST_LOSE;
            end
            ST_RELEASE: begin
                if (pins.buttons == '0) begin
                    if (!last_idx)         state_next = ST_INPUT;
                    else if (round == LEN) state_next = ST_WIN;
                    else                   state_next = ST_SHOW_ON;
                end
            end
            ST_WIN, ST_LOSE: if (start) state_next = ST_GEN;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        pins.colour_out = (state == ST_SHOW_ON) ? cur_onehot : '0;
        pins.colour_oe  = (state == ST_SHOW_ON) && (cur_onehot != '0);
        state_dbg       = state;
        win             = (state == ST_WIN);
        lose            = (state == ST_LOSE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round        <= '0;
            index        <= '0;
            gen_idx      <= '0;
            disp_cnt     <= '0;
            tmo_cnt      <= '0;
            prev_buttons <= '0;
        end else begin
            prev_buttons <= pins.buttons;
            gen_idx  <= (state == ST_GEN && state_next == ST_GEN) ? gen_idx + IW'(1) : '0;
            disp_cnt <= ((state == ST_SHOW_ON || state == ST_SHOW_OFF) && !disp_done)
                        ? disp_cnt + DW'(1) : '0;
            tmo_cnt  <= (state == ST_INPUT && !press) ? tmo_cnt + TW'(1) : '0;

            if (state == ST_GEN && state_next == ST_SHOW_ON)
                round <= RW'(1);
            else if (state == ST_RELEASE && state_next == ST_SHOW_ON)
                round <= round + RW'(1);

            if (state == ST_GEN)
                index <= '0;
            else if (state == ST_SHOW_OFF && disp_done)
                index <= last_idx ? '0 : index + IW'(1);
            else if (state == ST_RELEASE && state_next == ST_INPUT)
                index <= index + IW'(1);
            else if (state == ST_RELEASE && state_next == ST_SHOW_ON)
                index <= '0;
        end
    end

    // Contents are rewritten in GEN before any use, so no reset is needed.
    always_ff @(posedge clk) begin
        if (state == ST_GEN) mem[gen_idx] <= gen_colour;
    end

endmodule

// File: tb/tb_simon_seq_engine.sv
// Bench for simon_seq_engine: two instances (4 colours/4 rounds, 3 colours/3 rounds)
// driven by a game table, random presses and hand-written corner sequences.
module tb_simon_seq_engine;

  localparam int A_N = 4, A_ML = 4, A_D = 4, A_T = 20;
  localparam int B_N = 3, B_ML = 3, B_D = 2, B_T = 20;

  typedef struct {
    bit         sel;
    bit         from_idle;
    logic [7:0] seed;
    int         fail_round;
    int         fail_idx;
    bit         fail_timeout;
    int         exp_state;
    int         exp_round;
  } game_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_v;
  logic [7:0] seed;
  logic [7:0] btn;
  bit         sel;

  simon_seq_engine_if #(.N_COLOURS(A_N)) if_a ();
  simon_seq_engine_if #(.N_COLOURS(B_N)) if_b ();

  logic [2:0] a_state, b_state;
  logic [2:0] a_round;
  logic [1:0] b_round;
  logic       a_win, a_lose, b_win, b_lose;

  assign if_a.buttons = sel ? '0 : btn[A_N-1:0];
  assign if_b.buttons = sel ? btn[B_N-1:0] : '0;

  simon_seq_engine #(.N_COLOURS(A_N), .MAX_LEN(A_ML), .DISPLAY_CYCLES(A_D), .TIMEOUT_CYCLES(A_T)) dut_a (
    .clk(clk), .rst(rst), .start(start_v & ~sel), .seed(seed), .pins(if_a),
    .state_dbg(a_state), .round(a_round), .win(a_win), .lose(a_lose));

  simon_seq_engine #(.N_COLOURS(B_N), .MAX_LEN(B_ML), .DISPLAY_CYCLES(B_D), .TIMEOUT_CYCLES(B_T)) dut_b (
    .clk(clk), .rst(rst), .start(start_v & sel), .seed(seed), .pins(if_b),
    .state_dbg(b_state), .round(b_round), .win(b_win), .lose(b_lose));

  always #5 clk = ~clk;

  // Observed outputs of whichever instance is selected
  logic [7:0] o_colour;
  logic       o_oe, o_win, o_lose;
  logic [2:0] o_state;
  logic [7:0] o_round;
  always_comb begin
    if (sel) begin
      o_colour = 8'(if_b.colour_out); o_oe = if_b.colour_oe; o_state = b_state;
      o_round = 8'(b_round); o_win = b_win; o_lose = b_lose;
    end else begin
      o_colour = 8'(if_a.colour_out); o_oe = if_a.colour_oe; o_state = a_state;
      o_round = 8'(a_round); o_win = a_win; o_lose = a_lose;
    end
  end

  // Scoreboard state and reference model
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mdl_lfsr [2];
  int         exp_seq [32];

  function automatic int p_n();  return sel ? B_N  : A_N;  endfunction
  function automatic int p_ml(); return sel ? B_ML : A_ML; endfunction
  function automatic int p_d();  return sel ? B_D  : A_D;  endfunction
  function automatic int p_t();  return sel ? B_T  : A_T;  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return (x % 2 == 1) ? ((x / 2) ^ 8'hB8) : (x / 2);
  endfunction

  function automatic logic [31:0] obs();
    return {10'd0, o_state, o_win, o_lose, o_oe, o_colour, o_round};
  endfunction

  function automatic logic [31:0] snap(input int st, input int col, input int rnd);
    return {10'd0, 3'(st), st == 6, st == 7, col != 0, 8'(col), 8'(rnd)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [7:0] s, input bit from_idle);
    logic [7:0] x;
    int v, m, cw;
    cw = 1;
    while ((1 << cw) < p_n()) cw++;
    m = 1 << cw;
    if (from_idle) mdl_lfsr[sel] = (s == 8'h00) ? 8'h01 : s;
    x = mdl_lfsr[sel];
    for (int g = 0; g < p_ml(); g++) begin
      v = int'(x) % m;
      if (v >= p_n()) v -= p_n();
      exp_seq[g] = v;
      x = lfsr_next(x);
    end
    mdl_lfsr[sel] = x;
    seed = s; start_v = 1'b1;
    tick();
    start_v = 1'b0;
    chk("gen_enter", 32'(o_state), 32'd1);
    repeat (p_ml() - 1) tick();
    chk("gen_last", 32'(o_state), 32'd1);
    tick();
    chk("first_lit", obs(), snap(2, 1 << exp_seq[0], 1));
  endtask

  // Enters in the first SHOW_ON cycle of round r, returns in the first INPUT cycle.
  task automatic show_round(input int r, input logic [7:0] hold);
    for (int i = 0; i < r; i++) begin
      for (int c = 0; c < p_d(); c++) begin
        chk("show_on", obs(), snap(2, 1 << exp_seq[i], r));
        tick();
      end
      for (int c = 0; c < p_d(); c++) begin
        chk("show_off", obs(), snap(3, 0, r));
        if (i == r - 1 && c == p_d() - 1) btn = hold;
        tick();
      end
    end
    chk("input_enter", obs(), snap(4, 0, r));
  endtask

  task automatic press_ok(input int r, input int i, input int hold_cycles);
    btn = 8'(1 << exp_seq[i]);
    tick();
    chk("press_accept", obs(), snap(5, 0, r));
    repeat (hold_cycles) begin
      tick();
      chk("release_hold", obs(), snap(5, 0, r));
    end
    btn = 8'h00;
    tick();
    if (i < r - 1)        chk("next_input", obs(), snap(4, 0, r));
    else if (r == p_ml()) chk("win", obs(), snap(6, 0, r));
    else                  chk("next_round", obs(), snap(2, 1 << exp_seq[0], r + 1));
  endtask

  task automatic run_game(input game_t g);
    int wrong;
    sel = g.sel;
    start_game(g.seed, g.from_idle);
    for (int r = 1; r <= p_ml(); r++) begin
      show_round(r, 8'h00);
      for (int i = 0; i < r; i++) begin
        if (r == g.fail_round && i == g.fail_idx) begin
          if (g.fail_timeout) begin
            for (int k = 1; k < p_t(); k++) begin
              tick();
              chk("tmo_not_yet", obs(), snap(4, 0, r));
            end
            tick();
          end else begin
            wrong = (exp_seq[i] + int'($urandom_range(1, p_n() - 1))) % p_n();
            btn = 8'(1 << wrong);
            tick();
            btn = 8'h00;
          end
          chk("lose", obs(), snap(7, 0, r));
          return;
        end
        repeat ($urandom_range(0, 3)) begin
          tick();
          chk("input_wait", obs(), snap(4, 0, r));
        end
        press_ok(r, i, int'($urandom_range(0, 2)));
      end
    end
  endtask

  initial begin
    game_t vecs[7];
    vecs[0] = '{sel:0, from_idle:1, seed:8'h00, fail_round:0, fail_idx:0, fail_timeout:0, exp_state:6, exp_round:4};
    vecs[1] = '{sel:0, from_idle:0, seed:8'h33, fail_round:2, fail_idx:1, fail_timeout:0, exp_state:7, exp_round:2};
    vecs[2] = '{sel:0, from_idle:0, seed:8'h00, fail_round:1, fail_idx:0, fail_timeout:1, exp_state:7, exp_round:1};
    vecs[3] = '{sel:0, from_idle:0, seed:8'h00, fail_round:0, fail_idx:0, fail_timeout:0, exp_state:6, exp_round:4};
    vecs[4] = '{sel:1, from_idle:1, seed:8'($urandom_range(0, 255)), fail_round:0, fail_idx:0, fail_timeout:0, exp_state:6, exp_round:3};
    vecs[5] = '{sel:1, from_idle:0, seed:8'h00, fail_round:3, fail_idx:2, fail_timeout:0, exp_state:7, exp_round:3};
    vecs[6] = '{sel:1, from_idle:0, seed:8'h00, fail_round:0, fail_idx:0, fail_timeout:0, exp_state:6, exp_round:3};

    rst = 1'b1; start_v = 1'b0; seed = 8'h00; btn = 8'h00; sel = 1'b0;
    mdl_lfsr[0] = 8'h01; mdl_lfsr[1] = 8'h01;
    repeat (2) tick();
    chk("reset_a", obs(), snap(0, 0, 0));
    sel = 1'b1; #1;
    chk("reset_b", obs(), snap(0, 0, 0));
    sel = 1'b0;
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_hold", obs(), snap(0, 0, 0));

    for (int v = 0; v < 7; v++) begin
      run_game(vecs[v]);
      chk("vec_outcome", {24'd0, 3'(o_state), 5'(o_round)},
          {24'd0, 3'(vecs[v].exp_state), 5'(vecs[v].exp_round)});
      tick();
    end

    // Instance A sits in WIN; replay it with the multi-cycle corner cases.
    sel = 1'b0;
    start_game(8'h5A, 1'b0);
    show_round(1, 8'h00);
    for (int k = 1; k < A_T; k++) begin
      tick();
      chk("late_wait", obs(), snap(4, 0, 1));
    end
    press_ok(1, 0, 0);

    show_round(2, 8'h00);
    btn = 8'b0011;
    tick();
    chk("multi_hot_ignored", obs(), snap(4, 0, 2));
    btn = 8'h00;
    tick();
    chk("zero_after_multi", obs(), snap(4, 0, 2));
    press_ok(2, 0, 0);
    press_ok(2, 1, 0);

    show_round(3, 8'(1 << exp_seq[0]));
    repeat (3) begin
      tick();
      chk("held_ignored", obs(), snap(4, 0, 3));
    end
    btn = 8'h00;
    tick();
    chk("held_released", obs(), snap(4, 0, 3));
    press_ok(3, 0, 0);
    press_ok(3, 1, 0);
    press_ok(3, 2, 0);

    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    chk("start_ignored", obs(), snap(2, 1 << exp_seq[0], 4));
    tick();
    rst = 1'b1;
    #1;
    chk("rst_async", obs(), snap(0, 0, 0));
    tick();
    rst = 1'b0;
    tick();
    chk("after_rst", obs(), snap(0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/simon_seq_engine.md
# simon_seq_engine

Parametrised Simon Says game core. It replaces the fixed four-colour, enable-chained IDLE/DISPLAY/WAIT/CHECK flow with a single state machine. Channel count, maximum sequence length, display pacing and input timeout are all configurable, and the block adds timeout loss plus a win/lose indication. It sits between the board button/LED pins and the tile top.

## Interface
Parameters:
- N_COLOURS, 4: number of colour channels, legal range 2..8; CW = max(1, clog2(N_COLOURS)).
- MAX_LEN, 16: rounds to win, legal range 1..32; RW = clog2(MAX_LEN+1).
- DISPLAY_CYCLES, 1000: cycles each colour is lit, and cycles of dark gap after it; ≥1.
- TIMEOUT_CYCLES, 100000: idle cycles allowed in INPUT before loss; ≥1.

Ports:
- clk, in, 1: the single clock; all state is updated on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: level sampled each clock; honoured only in IDLE, WIN or LOSE.
- seed, in, 8: LFSR seed, loaded when leaving IDLE; the value 0 is replaced by 8'h01.
- buttons, in, N_COLOURS: one bit per colour, active-high, already synchronous to clk.
- colour_out, out, N_COLOURS: one-hot lit colour during SHOW_ON, otherwise 0.
- colour_oe, out, 1: high exactly when colour_out ≠ 0.
- state_dbg, out, 3: current state encoding.
- round, out, RW: current round number.
- win, out, 1: high while in WIN.
- lose, out, 1: high while in LOSE.

## Operation
- States and encodings: IDLE = 0, GEN = 1, SHOW_ON = 2, SHOW_OFF = 3, INPUT = 4, RELEASE = 5, WIN = 6, LOSE = 7.
- IDLE: on start = 1, load the LFSR with seed (or with 8'h01 if seed = 0), then go to GEN.
- GEN: runs MAX_LEN cycles. Each cycle it writes one entry to mem[g], g = 0..MAX_LEN-1, and steps the LFSR once.
- GEN colour value: v = lfsr[CW-1:0]. If v ≥ N_COLOURS, store v − N_COLOURS.
- GEN exit: go to SHOW_ON with round = 1 and index = 0.
- SHOW_ON: colour_out = onehot(mem[index]) for DISPLAY_CYCLES cycles, then go to SHOW_OFF.
- SHOW_OFF: outputs dark for DISPLAY_CYCLES cycles. Then, if index = round−1, clear index and go to INPUT. Otherwise increment index and go to SHOW_ON.
- INPUT, press detection: a press is detected in the cycle where buttons is exactly one-hot and the previous cycle's buttons was all-zero.
- INPUT, ignored inputs: multi-hot values and held buttons carried over from before are not presses.
- INPUT, compare: on a detected press, compare the pressed colour to mem[index].
  - Mismatch: go to LOSE.
  - Match: go to RELEASE.
- INPUT, timeout: the timeout counter resets on entry to INPUT and on every detected press. At TIMEOUT_CYCLES with no press, go to LOSE.
- RELEASE: wait for buttons = 0. Then:
  - If index < round−1: increment index and return to INPUT.
  - Else if round = MAX_LEN: go to WIN.
  - Else: increment round, clear index, go to SHOW_ON.
- WIN and LOSE: hold state, with round frozen. On start = 1, reload nothing and go to GEN. The LFSR continues from its current value, so a fresh sequence is produced.
- Other states: start is ignored.
- The LFSR is 8-bit Galois, right-shifting, taps mask 8'hB8. It steps only in GEN.

## Timing
- Reset values: state = IDLE, round = 0, index = 0, all counters 0, LFSR = 8'h01.
- Outputs under reset: colour_out = 0, colour_oe = 0, win = 0, lose = 0.
- All outputs are registered, or decoded directly from registered state; there is no combinational input-to-output path.
- IDLE → GEN occurs on the edge that samples start = 1. GEN lasts exactly MAX_LEN cycles.
- The first colour is lit in the cycle after the last GEN write.
- Round r display: lasts 2·r·DISPLAY_CYCLES cycles.
- Press evaluation: the state transition happens on the edge after the press cycle; latency is 1.
- Simultaneous timeout and press in the same cycle: the press wins.
- rst asserted mid-game: immediate return to reset values. The sequence memory contents are don't-care, because GEN rewrites every entry before use.

## Structure
- Shared package simon_pkg holds:
  - the state enum and its encodings;
  - LFSR_TAPS = 8'hB8;
  - the width helper functions for CW and RW.
- Sub-module simon_lfsr: ports clk, rst, load, seed, step, q.
- Sequence memory is a MAX_LEN × CW register array inside the engine. No SRAM macro is used.

## Test plan
- Case 1, seed 8'h00, N_COLOURS = 4, start pulse: LFSR holds 8'h01 after load.
  - mem[0..3] equals the model sequence, which comes from a reference Galois LFSR with mask 8'hB8.
  - First SHOW_ON lights onehot(mem[0]) for DISPLAY_CYCLES = 4 cycles.
- Case 2, MAX_LEN = 3, correct presses every round: round goes 1 → 2 → 3, then WIN.
  - win = 1 and state_dbg = 6.
  - Start from WIN re-enters GEN and produces a different sequence.
- Case 3, wrong colour in round 2, index 1: LOSE on the following edge, lose = 1, round = 2.
- Case 4, no press in INPUT, TIMEOUT_CYCLES = 20: LOSE exactly 20 cycles after INPUT entry.
  - A second run with a press at cycle 19 must not lose.
- Case 5, buttons = 4'b0011, then 4'b0000, then the correct one-hot: the multi-hot value is ignored and the one-hot press is accepted.
  - A held button carried into INPUT is not counted until it is released and re-pressed.
- Case 6, N_COLOURS = 3, and separately rst asserted during SHOW_ON:
  - N_COLOURS = 3: no stored colour is ever ≥ 3.
  - rst during SHOW_ON: colour_out = 0 asynchronously and state_dbg = 0.
